// File: rtl/test_in_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : test_in_gen_if
//  Brief    : Write side of a ping-pong FIFO (grant, size, strobe, data)
//  Revision : 1.0
// ============================================================================
interface test_in_gen_if #(
    parameter int DATA_WIDTH = 32,
    parameter int SIZE_WIDTH = 24
);
    logic [1:0]            ready;
    logic [1:0]            activate;
    logic [SIZE_WIDTH-1:0] fifo_size;
    logic                  strobe;
    logic [DATA_WIDTH-1:0] data;

    modport master (
        input  ready,
        input  fifo_size,
        output activate,
        output strobe,
        output data
    );

    modport slave (
        output ready,
        output fifo_size,
        input  activate,
        input  strobe,
        input  data
    );
endinterface
`default_nettype wire

// File: rtl/test_in_gen.sv
`default_nettype none
// ============================================================================
//  Module   : test_in_gen
//  Brief    : Test data source filling a ping-pong FIFO write side.
//             Define TEST_IN_GEN_LFSR_EN for a 32-bit LFSR pattern
//             (DATA_WIDTH must be 32); otherwise an incrementing counter.
//  Revision : 1.0
// ============================================================================
module test_in_gen #(
    parameter int DATA_WIDTH = 32,
    parameter int SIZE_WIDTH = 24
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  enable,
    input  wire logic [SIZE_WIDTH-1:0] write_count,
    output logic                       finished,
    test_in_gen_if.master              bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_GRANT   = 3'd1;
    localparam logic [2:0] S_WRITE   = 3'd2;
    localparam logic [2:0] S_RELEASE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

`ifdef TEST_IN_GEN_LFSR_EN
    localparam logic [DATA_WIDTH-1:0] c_PAT_SEED = DATA_WIDTH'(32'h0000_0001);
`else
    localparam logic [DATA_WIDTH-1:0] c_PAT_SEED = '0;
`endif

    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic [1:0]            r_activate;
    logic                  r_strobe;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] r_pattern;
    logic [SIZE_WIDTH-1:0] r_bcount;
    logic [SIZE_WIDTH-1:0] r_total;
    logic                  r_finished;
    logic                  r_sel;

    logic [1:0]            w_activate_nxt;
    logic                  w_strobe_nxt;
    logic [DATA_WIDTH-1:0] w_data_nxt;
    logic [DATA_WIDTH-1:0] w_pattern_nxt;
    logic [SIZE_WIDTH-1:0] w_bcount_nxt;
    logic [SIZE_WIDTH-1:0] w_total_nxt;
    logic                  w_finished_nxt;
    logic                  w_sel_nxt;
    logic                  w_room;
    logic                  w_total_met;
    logic [DATA_WIDTH-1:0] w_pattern_adv;

    assign w_room      = (r_bcount < bus.fifo_size) && (r_total < write_count);
    assign w_total_met = (r_total == write_count);

`ifdef TEST_IN_GEN_LFSR_EN
    assign w_pattern_adv = {r_pattern[30:0],
                            r_pattern[31] ^ r_pattern[21] ^ r_pattern[1] ^ r_pattern[0]};
`else
    assign w_pattern_adv = r_pattern + DATA_WIDTH'(1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    if (w_total_met) begin
                        w_state_nxt = S_DONE;
                    end else if ((bus.ready != 2'b00) && (r_activate == 2'b00)) begin
                        w_state_nxt = S_GRANT;
                    end
                end
            end
            S_GRANT:   w_state_nxt = S_WRITE;
            S_WRITE:   if (!w_room) w_state_nxt = S_RELEASE;
            S_RELEASE: w_state_nxt = S_IDLE;
            S_DONE:    if (!enable) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and counters; strobe is a one-cycle pulse.
    always_comb begin
        w_activate_nxt = r_activate;
        w_strobe_nxt   = 1'b0;
        w_data_nxt     = r_data;
        w_pattern_nxt  = r_pattern;
        w_bcount_nxt   = r_bcount;
        w_total_nxt    = r_total;
        w_finished_nxt = r_finished;
        w_sel_nxt      = r_sel;
        case (r_state)
            S_IDLE: begin
                if (!enable) begin
                    w_total_nxt    = '0;
                    w_pattern_nxt  = c_PAT_SEED;
                    w_finished_nxt = 1'b0;
                end else if (w_total_met) begin
                    w_finished_nxt = 1'b1;
                end else if (bus.ready != 2'b00) begin
                    w_sel_nxt = ~bus.ready[0];
                end
            end
            S_GRANT: begin
                w_activate_nxt = r_sel ? 2'b10 : 2'b01;
                w_bcount_nxt   = '0;
            end
            S_WRITE: begin
                if (w_room) begin
                    w_strobe_nxt  = 1'b1;
                    w_data_nxt    = r_pattern;
                    w_bcount_nxt  = r_bcount + SIZE_WIDTH'(1);
                    w_total_nxt   = r_total + SIZE_WIDTH'(1);
                    w_pattern_nxt = w_pattern_adv;
                end
            end
            S_RELEASE: w_activate_nxt = 2'b00;
            S_DONE:    w_finished_nxt = 1'b1;
            default:   w_activate_nxt = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_activate <= 2'b00;
            r_strobe   <= 1'b0;
            r_data     <= '0;
            r_pattern  <= c_PAT_SEED;
            r_bcount   <= '0;
            r_total    <= '0;
            r_finished <= 1'b0;
            r_sel      <= 1'b0;
        end else begin
            r_activate <= w_activate_nxt;
            r_strobe   <= w_strobe_nxt;
            r_data     <= w_data_nxt;
            r_pattern  <= w_pattern_nxt;
            r_bcount   <= w_bcount_nxt;
            r_total    <= w_total_nxt;
            r_finished <= w_finished_nxt;
            r_sel      <= w_sel_nxt;
        end
    end

    assign bus.activate = r_activate;
    assign bus.strobe   = r_strobe;
    assign bus.data     = r_data;
    assign finished     = r_finished;

endmodule
`default_nettype wire

// File: tb/tb_test_in_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_test_in_gen
//  Brief    : Randomized self-checking bench for test_in_gen
//  Revision : 1.0
// ============================================================================
module tb_test_in_gen;

    localparam int DW = 32;
    localparam int SW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [SW-1:0] write_count;
    logic          finished;

    int n_assert = 0;
    int n_fail   = 0;

    test_in_gen_if #(.DATA_WIDTH(DW), .SIZE_WIDTH(SW)) bus ();

    test_in_gen #(.DATA_WIDTH(DW), .SIZE_WIDTH(SW)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .write_count (write_count),
        .finished    (finished),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pat_first();
`ifdef TEST_IN_GEN_LFSR_EN
        return 32'h0000_0001;
`else
        return 32'h0000_0000;
`endif
    endfunction

    function automatic logic [31:0] pat_next(input logic [31:0] d);
`ifdef TEST_IN_GEN_LFSR_EN
        return {d[30:0], d[31] ^ d[21] ^ d[1] ^ d[0]};
`else
        return d + 32'd1;
`endif
    endfunction

    // One run: words must form one continuous pattern stream, split into
    // grants of min(fifo_size, remaining) words each. In ping-pong mode a
    // buffer stops being ready once granted and refills while the other is used.
    task automatic run_case(input int fs, input int wc, input logic [1:0] rdy, input bit pingpong);
        int          words = 0;
        int          grant_words = 0;
        int          words_at_rise = 0;
        int          grants = 0;
        int          since_rise = 0;
        int          exp_len;
        bit          done = 0;
        logic [1:0]  prev_act = 2'b00;
        logic        prev_strobe = 1'b0;
        logic [1:0]  exp_grant;
        logic [31:0] exp_data = pat_first();

        bus.fifo_size = SW'(fs);
        write_count   = SW'(wc);
        bus.ready     = pingpong ? 2'b11 : rdy;
        exp_grant     = (pingpong || rdy[0]) ? 2'b01 : 2'b10;
        enable        = 1'b1;
        for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
            @(negedge clk);
            if (bus.strobe) check_eq("strobe_without_activate", {63'd0, bus.activate == 2'b00}, 64'd0);
            if (bus.activate == 2'b11) check_eq("activate_two_hot", bus.activate, 2'b01);
            if (bus.activate != 2'b00 && prev_act == 2'b00) begin
                grants++;
                check_eq("grant_buffer", bus.activate, exp_grant);
                grant_words   = 0;
                words_at_rise = words;
                since_rise    = 0;
                if (pingpong) begin
                    bus.ready = (bus.activate == 2'b01) ? 2'b10 : 2'b01;
                    exp_grant = (bus.activate == 2'b01) ? 2'b10 : 2'b01;
                end
            end else if (bus.activate != 2'b00) begin
                since_rise++;
            end
            if (bus.strobe) begin
                check_eq("data", bus.data, exp_data);
                check_eq("strobe_slot", since_rise, grant_words + 1);
                exp_data = pat_next(exp_data);
                words++;
                grant_words++;
            end
            if (bus.activate == 2'b00 && prev_act != 2'b00) begin
                exp_len = (wc - words_at_rise < fs) ? wc - words_at_rise : fs;
                check_eq("grant_words", grant_words, exp_len);
                check_eq("release_after_strobe", prev_strobe, 1'b0);
            end
            if (finished) begin
                done = 1;
                check_eq("total_words", words, wc);
                check_eq("done_activate", bus.activate, 2'b00);
            end
            prev_act    = bus.activate;
            prev_strobe = bus.strobe;
        end
        check_eq("finish_within_budget", done, 1'b1);
        check_eq("grant_count", grants, (wc == 0) ? 0 : (wc + fs - 1) / fs);
        @(negedge clk);
        check_eq("finished_held", finished, 1'b1);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("finished_cleared", finished, 1'b0);
    endtask

    task automatic zero_size_case();
        int strobes = 0;
        int pulses = 0;
        int len = 0;
        bus.fifo_size = '0;
        write_count   = SW'(5);
        bus.ready     = 2'b01;
        enable        = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (bus.strobe) strobes++;
            if (bus.activate != 2'b00) begin
                len++;
            end else if (len != 0) begin
                pulses++;
                check_eq("zero_size_pulse_len", len, 2);
                len = 0;
            end
        end
        check_eq("zero_size_no_strobe", strobes, 0);
        check_eq("zero_size_retries", {63'd0, pulses >= 10}, 64'd1);
        check_eq("zero_size_not_finished", finished, 1'b0);
        enable = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic reset_mid_buffer();
        int strobes = 0;
        bus.fifo_size = SW'(8);
        write_count   = SW'(8);
        bus.ready     = 2'b01;
        enable        = 1'b1;
        for (int cyc = 0; cyc < 50 && strobes < 2; cyc++) begin
            @(negedge clk);
            if (bus.strobe) strobes++;
        end
        check_eq("reset_mid_reached", strobes, 2);
        rst = 1'b1;
        @(negedge clk);
        check_eq("reset_mid_activate", bus.activate, 2'b00);
        check_eq("reset_mid_strobe", bus.strobe, 1'b0);
        check_eq("reset_mid_data", bus.data, 32'd0);
        rst = 1'b0;
        run_case(8, 8, 2'b01, 1'b0);
    endtask

    initial begin
        rst           = 1'b1;
        enable        = 1'b0;
        write_count   = '0;
        bus.ready     = 2'b00;
        bus.fifo_size = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_activate", bus.activate, 2'b00);
        check_eq("reset_strobe", bus.strobe, 1'b0);
        check_eq("reset_data", bus.data, 32'd0);
        check_eq("reset_finished", finished, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        run_case(4, 4, 2'b01, 1'b0);
        run_case(4, 10, 2'b11, 1'b1);
        run_case(4, 0, 2'b01, 1'b0);
        run_case(4, 3, 2'b10, 1'b0);
        run_case(3, 3, 2'b11, 1'b0);
        zero_size_case();
        reset_mid_buffer();
        for (int i = 0; i < 12; i++) begin
            run_case(int'($urandom_range(1, 6)), int'($urandom_range(0, 20)),
                     2'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
